queue_drain: RTL and testbench
==============================

# queue_drain

Pop-side drain for a `queue_rf` instance. It consumes the queue's empty/pop-data status and issues pops. Popped entries are buffered in a small registered output stage and presented downstream as a valid/ready stream. It sits between any `queue_rf` and a consumer that needs a registered, backpressurable interface, and it breaks the combinational path from downstream ready into queue pop logic.

## Interface
- `W`, default 32, width of each entry; must match the attached queue.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_q_empty_w`  in  1  queue empty status (combinational from queue).
- `i_q_pop_dat`  in  W  queue head data; valid whenever `i_q_empty_w`=0.
- `o_q_pop`  out  1  pop strobe to the queue; never asserted while `i_q_empty_w`=1.
- `o_valid`  out  1  downstream data valid.
- `o_dat`  out  W  downstream data (head of output buffer).
- `i_ready`  in  1  downstream ready; a transfer occurs when `o_valid & i_ready`.
- `i_flush`  in  1  discard all buffered entries.
- `o_busy`  out  1  `o_valid | !i_q_empty_w`.

## Operation
- Output buffer occupancy is `cnt_r`. With the skid stage it has states EMPTY(0), ONE(1) and TWO(2). Without it, the states are EMPTY and ONE.
- Capture: on an edge where `o_q_pop`=1, `i_q_pop_dat` is written to the buffer tail.
- Consume: on an edge where `o_valid & i_ready`, the head is retired and the second entry (if any) becomes the head.
- State transitions (skid build):
  - EMPTY -pop-> ONE.
  - ONE -pop & !consume-> TWO.
  - ONE -pop & consume-> ONE.
  - ONE -consume & !pop-> EMPTY.
  - TWO -consume-> ONE.
  - Pop in TWO is illegal and never generated.
- `o_valid` = `cnt_r != 0`, purely registered.
- `o_dat` is a registered head entry with no mux from `i_q_pop_dat`.
- Entries appear on `o_dat` in pop order; the drain never duplicates, drops or reorders entries except on flush.
- Flush:
  - `i_flush`=1 forces `o_q_pop`=0 that cycle.
  - `cnt_r` becomes 0 at the next edge.
  - A handshake that completes in the flush cycle counts as delivered.
  - Queue contents are not touched; the owner flushes the queue separately.
- Reset:
  - `rst`=1 forces `o_q_pop`=0.
  - Next state: `cnt_r`=0, `o_valid`=0, `o_dat`=0, all buffer entries 0.
  - Reset asserted mid-transfer discards buffered entries, same as flush.
- Outputs after reset: `o_valid`=0, `o_dat`=0, `o_q_pop`=0 while `rst` is high, and `o_busy`=`!i_q_empty_w`.

## Timing
- Pop-to-valid latency is 1 cycle: data popped at edge N is on `o_dat` with `o_valid`=1 after edge N.
- Throughput is 1 entry/cycle sustained when the queue is non-empty and `i_ready`=1. Steady state is ONE with pop and consume every cycle.
- Skid build: `o_q_pop` = `!rst & !i_flush & !i_q_empty_w & (cnt_r != 2)`. This has no dependence on `i_ready`.
- Non-skid build: `o_q_pop` = `!rst & !i_flush & !i_q_empty_w & (cnt_r == 0 | i_ready)`. This creates a combinational path from `i_ready` to `o_q_pop`.
- Backpressure: with `i_ready`=0, the skid build absorbs at most 2 entries, then stops popping. Behaviour is the same whether or not the skid stage is enabled, apart from that depth and the ready path.
- Simultaneous pop and consume in ONE:
  - The head is replaced by the new entry.
  - `cnt_r` is unchanged.

## Configuration
- `QUEUE_DRAIN_SKID_EN` defined: 2-entry output buffer, and pop is independent of `i_ready`, which is the timing-clean build.
- Not defined:
  - 1-entry output register, so `o_q_pop` depends combinationally on `i_ready`.
  - Full throughput is retained and area is halved.
- The port list is identical in both builds.

## Structure
- Shared package `queue_pkg`: occupancy state typedef (`QUEUE_DRAIN_EMPTY`/`ONE`/`TWO`) and the `QUEUE_DRAIN_DEPTH` constant (2 or 1, selected by the macro).
- One sub-module, `queue_drain_buf`: W-wide, depth-parameterised register buffer with head/tail pointers, write-enable and retire inputs. The top holds the state machine and pop logic.
- Flops use the team's `H_DFF`/`H_DFFE` macros with synchronous reset.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles with queue non-empty → `o_q_pop`=0, `o_valid`=0, `o_dat`=0, `o_busy`=1.
- Streaming: queue preloaded with 0x10..0x17, `i_ready`=1 → 8 consecutive pops. `o_dat` shows 0x10..0x17 on consecutive cycles starting 1 cycle after the first pop, with no bubbles.
- Backpressure (skid build): 4 entries 0xA0..0xA3, `i_ready`=0 → exactly 2 pops, `cnt_r`=2, `o_dat`=0xA0. Release `i_ready` → 0xA0..0xA3 delivered in order with no loss.
- Pop+consume in ONE: single entry 0x55 buffered, push 0x66 to the queue, `i_ready`=1 → 0x55 transfers and 0x66 appears the next cycle, with `cnt_r` held at 1.
- Flush: `cnt_r`=2 holding 0x1, 0x2, and `i_flush`=1 with `i_ready`=1 → 0x1 delivered, `o_q_pop`=0 that cycle, `o_valid`=0 the next cycle, and 0x2 never appears.
- Empty boundary: queue empty, `i_ready` toggling → `o_q_pop` never asserts, `o_valid` stays 0 and `o_busy`=0.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared definitions for the queue_drain slice: occupancy states, flop macros and buffer depth.
// Define QUEUE_DRAIN_SKID_EN for the 2-entry skid buffer; otherwise a single output register is built.
`ifndef H_DFF
`define H_DFF(clk, rst, q, d) always_ff @(posedge clk) if (rst) q <= '0; else q <= (d);
`endif
`ifndef H_DFFE
`define H_DFFE(clk, rst, q, d, en) always_ff @(posedge clk) if (rst) q <= '0; else if (en) q <= (d);
`endif

package queue_pkg;

  typedef enum logic [1:0] {
    QUEUE_DRAIN_EMPTY = 2'd0,
    QUEUE_DRAIN_ONE   = 2'd1,
    QUEUE_DRAIN_TWO   = 2'd2
  } queue_drain_state_e;

`ifdef QUEUE_DRAIN_SKID_EN
  localparam int QUEUE_DRAIN_DEPTH = 2;
`else
  localparam int QUEUE_DRAIN_DEPTH = 1;
`endif

endpackage

// File: rtl/queue_drain_buf.sv
// Output buffer for queue_drain: entries written at the tail, retired from the head.
// A depth of one collapses to a plain enabled register with no pointers.
module queue_drain_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         retire,
  output logic [W-1:0] head_dat
);

  generate
    if (DEPTH == 1) begin : g_single
      logic [W-1:0] ent_r;
      logic         unused_ctl;

      // A lone entry is simply overwritten; retire and clear only matter to the occupancy count.
      assign unused_ctl = &{1'b0, clr, retire};

      `H_DFFE(clk, rst, ent_r, wr_dat, wr_en)

      assign head_dat = ent_r;
    end else begin : g_ring
      localparam int PW = $clog2(DEPTH);

      logic [W-1:0]  mem_r [DEPTH];
      logic [PW-1:0] head_r;
      logic [PW-1:0] tail_r;
      logic [PW-1:0] head_nxt;
      logic [PW-1:0] tail_nxt;

      function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
      endfunction

      assign head_nxt = clr ? '0 : (retire ? ptr_inc(head_r) : head_r);
      assign tail_nxt = clr ? '0 : (wr_en  ? ptr_inc(tail_r) : tail_r);

      `H_DFF(clk, rst, head_r, head_nxt)
      `H_DFF(clk, rst, tail_r, tail_nxt)

      for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        `H_DFFE(clk, rst, mem_r[i], wr_dat, wr_en && (tail_r == PW'(i)))
      end

      assign head_dat = mem_r[head_r];
    end
  endgenerate

endmodule

// File: rtl/queue_drain.sv
// Pop-side drain for queue_rf: pops into a registered output buffer and presents a valid/ready stream.
// QUEUE_DRAIN_SKID_EN selects the 2-deep buffer whose pop does not depend on i_ready.
module queue_drain
  import queue_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_q_empty_w,
  input  logic [W-1:0] i_q_pop_dat,
  output logic         o_q_pop,
  output logic         o_valid,
  output logic [W-1:0] o_dat,
  input  logic         i_ready,
  input  logic         i_flush,
  output logic         o_busy
);

  queue_drain_state_e cnt_r;
  logic               valid_r;
  logic               pop;
  logic               consume;

  assign consume = valid_r & i_ready;

`ifdef QUEUE_DRAIN_SKID_EN
  assign pop = !rst & !i_flush & !i_q_empty_w & (cnt_r != QUEUE_DRAIN_TWO);
`else
  // Single register: pop only when it is empty or being drained this very cycle.
  assign pop = !rst & !i_flush & !i_q_empty_w & ((cnt_r == QUEUE_DRAIN_EMPTY) | i_ready);
`endif

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      cnt_r   <= QUEUE_DRAIN_EMPTY;
      valid_r <= 1'b0;
    end else begin
      case (cnt_r)
        QUEUE_DRAIN_EMPTY: begin
          if (pop) begin
            cnt_r   <= QUEUE_DRAIN_ONE;
            valid_r <= 1'b1;
          end
        end
        QUEUE_DRAIN_ONE: begin
          if (pop && !consume) begin
            cnt_r <= QUEUE_DRAIN_TWO;
          end else if (consume && !pop) begin
            cnt_r   <= QUEUE_DRAIN_EMPTY;
            valid_r <= 1'b0;
          end
        end
        QUEUE_DRAIN_TWO: begin
          if (consume) begin
            cnt_r <= QUEUE_DRAIN_ONE;
          end
        end
        default: begin
          cnt_r   <= QUEUE_DRAIN_EMPTY;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  queue_drain_buf #(
    .W     (W),
    .DEPTH (QUEUE_DRAIN_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (i_flush),
    .wr_en    (pop),
    .wr_dat   (i_q_pop_dat),
    .retire   (consume),
    .head_dat (o_dat)
  );

  assign o_q_pop = pop;
  assign o_valid = valid_r;
  assign o_busy  = valid_r | !i_q_empty_w;

endmodule

// File: tb/tb_queue_drain.sv
// Directed bench for queue_drain; a queue model stands in for queue_rf.
// Depth-dependent expectations follow QUEUE_DRAIN_SKID_EN.
module tb_queue_drain;

`ifdef QUEUE_DRAIN_SKID_EN
  localparam int BP_POPS = 2;
`else
  localparam int BP_POPS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_q_empty_w;
  logic [31:0] i_q_pop_dat;
  logic        o_q_pop;
  logic        o_valid;
  logic [31:0] o_dat;
  logic        i_ready;
  logic        i_flush;
  logic        o_busy;

  logic [31:0] qm [$];
  int          cmp_count = 0;
  int          err_count = 0;
  int          pop_count = 0;

  queue_drain #(.W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_q_empty_w (i_q_empty_w),
    .i_q_pop_dat (i_q_pop_dat),
    .o_q_pop     (o_q_pop),
    .o_valid     (o_valid),
    .o_dat       (o_dat),
    .i_ready     (i_ready),
    .i_flush     (i_flush),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refreshQueue();
    i_q_empty_w = (qm.size() == 0);
    i_q_pop_dat = (qm.size() != 0) ? qm[0] : 32'hDEAD_BEEF;
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic fl);
    rst     = r;
    i_ready = rdy;
    i_flush = fl;
    refreshQueue();
    #1;
  endtask

  // Inputs only change at the falling edge, so o_q_pop sampled here is what the rising edge sees.
  task automatic tick();
    logic p;
    p = o_q_pop;
    checkOutput("pop_when_empty", 32'(p & i_q_empty_w), 32'h0);
    @(posedge clk);
    @(negedge clk);
    if (p) begin
      pop_count++;
      if (qm.size() != 0) void'(qm.pop_front());
    end
    refreshQueue();
    #1;
  endtask

  initial begin
    // Reset with a non-empty queue
    qm = '{32'h99};
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst_pop", 32'(o_q_pop), 32'h0);
    checkOutput("rst_busy", 32'(o_busy), 32'h1);
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput("rst_valid", 32'(o_valid), 32'h0);
      checkOutput("rst_dat", o_dat, 32'h0);
      checkOutput("rst_pop_hold", 32'(o_q_pop), 32'h0);
      checkOutput("rst_busy_hold", 32'(o_busy), 32'h1);
    end
    checkOutput("rst_no_pops", 32'(pop_count), 32'h0);

    // Empty queue, ready toggling
    qm.delete();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, c[0], 1'b0);
      checkOutput("empty_pop", 32'(o_q_pop), 32'h0);
      checkOutput("empty_valid", 32'(o_valid), 32'h0);
      checkOutput("empty_busy", 32'(o_busy), 32'h0);
      tick();
    end

    // Streaming 0x10..0x17 with ready held high
    for (int k = 0; k < 8; k++) qm.push_back(32'h10 + 32'(k));
    pop_count = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stream_first_pop", 32'(o_q_pop), 32'h1);
    checkOutput("stream_valid0", 32'(o_valid), 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput("stream_valid", 32'(o_valid), 32'h1);
      checkOutput("stream_dat", o_dat, 32'h10 + 32'(k));
    end
    tick();
    checkOutput("stream_end_valid", 32'(o_valid), 32'h0);
    checkOutput("stream_end_busy", 32'(o_busy), 32'h0);
    checkOutput("stream_pops", 32'(pop_count), 32'd8);

    // Backpressure: 0xA0..0xA3 with ready low, then release
    qm = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    pop_count = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("bp_pops", 32'(pop_count), 32'(BP_POPS));
    checkOutput("bp_valid", 32'(o_valid), 32'h1);
    checkOutput("bp_dat", o_dat, 32'hA0);
    checkOutput("bp_pop_stall", 32'(o_q_pop), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp_dlv_valid", 32'(o_valid), 32'h1);
      checkOutput("bp_dlv_dat", o_dat, 32'hA0 + 32'(k));
      tick();
    end
    checkOutput("bp_end_valid", 32'(o_valid), 32'h0);
    checkOutput("bp_total_pops", 32'(pop_count), 32'd4);

    // Pop and consume in the same cycle while one entry is held
    qm = '{32'h55};
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("pc_valid", 32'(o_valid), 32'h1);
    checkOutput("pc_dat", o_dat, 32'h55);
    qm.push_back(32'h66);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pc_pop", 32'(o_q_pop), 32'h1);
    tick();
    checkOutput("pc_next_valid", 32'(o_valid), 32'h1);
    checkOutput("pc_next_dat", o_dat, 32'h66);
    tick();
    checkOutput("pc_end_valid", 32'(o_valid), 32'h0);

    // Flush with a handshake in the same cycle
    qm = '{32'h1, 32'h2};
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("fl_head_valid", 32'(o_valid), 32'h1);
    checkOutput("fl_head_dat", o_dat, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("fl_pop", 32'(o_q_pop), 32'h0);
    checkOutput("fl_dlv_valid", 32'(o_valid), 32'h1);
    checkOutput("fl_dlv_dat", o_dat, 32'h1);
    tick();
    qm.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fl_after_valid", 32'(o_valid), 32'h0);
    tick();
    checkOutput("fl_after2_valid", 32'(o_valid), 32'h0);
    checkOutput("fl_after2_busy", 32'(o_busy), 32'h0);

    // Reset while an entry is buffered
    qm = '{32'h77};
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rm_valid", 32'(o_valid), 32'h1);
    checkOutput("rm_dat", o_dat, 32'h77);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rm_pop", 32'(o_q_pop), 32'h0);
    tick();
    checkOutput("rm_clr_valid", 32'(o_valid), 32'h0);
    checkOutput("rm_clr_dat", o_dat, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rm_busy", 32'(o_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
